// File: rtl/specialist_pkg.sv
// Shared types and constants for the SD-card-over-SDRAM sector server.
package specialist_pkg;

    localparam int unsigned ADDR_W       = 25;
    localparam int unsigned SIZE_W       = 32;
    localparam int unsigned LBA_W        = 32;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned IDX_W        = 9;
    localparam int unsigned SPAN_W       = 42;
    localparam int unsigned SECTOR_BYTES = 512;
    localparam int unsigned LBA_LOW_W    = ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_PUT,
        WR_ADDR,
        WR_MEM,
        NEXT,
        DONE
    } sd_state_t;

    // base + lba*512 + idx, wrapped to the SDRAM address width
    function automatic logic [ADDR_W-1:0] sector_addr(
        input logic [ADDR_W-1:0]    base,
        input logic [LBA_LOW_W-1:0] lba,
        input logic [IDX_W-1:0]     idx
    );
        return base + {lba, idx};
    endfunction

endpackage

// File: rtl/sd_ram_server.sv
// Serves SD sector reads/writes out of a disk image held in SDRAM and
// tracks the image size while it is being loaded.
module sd_ram_server
    import specialist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 25'h0100000,
    parameter logic [SIZE_W-1:0] MAX_SIZE  = 32'd1048576
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              load_active,
    input  logic              load_wr,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              img_mounted,
    output logic [SIZE_W-1:0] img_size,
    input  logic [LBA_W-1:0]  sd_lba,
    input  logic              sd_rd,
    input  logic              sd_wr,
    output logic              sd_ack,
    output logic [IDX_W-1:0]  sd_buff_addr,
    output logic [DATA_W-1:0] sd_buff_dout,
    output logic              sd_buff_wr,
    input  logic [DATA_W-1:0] sd_buff_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    input  logic              mem_ready
);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SECTOR_BYTES - 1);
    localparam logic [DATA_W-1:0] NULL_BYTE = 8'hFF;

    sd_state_t             state;
    logic                  load_d;
    logic [SIZE_W-1:0]     size;
    logic [LBA_LOW_W-1:0]  lba_q;
    logic [IDX_W-1:0]      idx;
    logic                  null_xfer;
    logic                  rd_xfer;

    logic [ADDR_W-1:0]     load_rel;
    logic [SIZE_W-1:0]     load_end;
    logic [SIZE_W-1:0]     size_base;
    logic [SPAN_W-1:0]     sector_end;
    logic                  in_range;
    logic [IDX_W-1:0]      idx_nxt;

    // Size tracking and sector range test
    assign load_rel   = load_addr - BASE_ADDR;
    assign load_end   = SIZE_W'(load_rel) + SIZE_W'(1);
    assign size_base  = (load_active && !load_d) ? '0 : size;
    assign sector_end = (SPAN_W'(sd_lba) + SPAN_W'(1)) << IDX_W;
    assign in_range   = sector_end <= SPAN_W'(img_size);
    assign idx_nxt    = idx + IDX_W'(1);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= IDLE;
            load_d       <= 1'b0;
            size         <= '0;
            img_size     <= '0;
            img_mounted  <= 1'b0;
            lba_q        <= '0;
            idx          <= '0;
            null_xfer    <= 1'b0;
            rd_xfer      <= 1'b0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_dout     <= '0;
            mem_rd       <= 1'b0;
            mem_we       <= 1'b0;
        end else begin
            load_d      <= load_active;
            img_mounted <= 1'b0;
            sd_buff_wr  <= 1'b0;

            if (load_active) begin
                size <= (load_wr && (load_end > size_base)) ? load_end : size_base;
            end
            if (!load_active && load_d) begin
                img_size    <= (size > MAX_SIZE) ? MAX_SIZE : size;
                img_mounted <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    if (!load_active && (sd_rd || sd_wr)) begin
                        lba_q        <= sd_lba[LBA_LOW_W-1:0];
                        idx          <= '0;
                        sd_ack       <= 1'b1;
                        null_xfer    <= !in_range;
                        rd_xfer      <= sd_rd;
                        sd_buff_addr <= '0;
                        if (sd_rd && !in_range) begin
                            sd_buff_dout <= NULL_BYTE;
                            sd_buff_wr   <= 1'b1;
                            state        <= RD_PUT;
                        end else if (sd_rd) begin
                            mem_addr <= sector_addr(BASE_ADDR, sd_lba[LBA_LOW_W-1:0], '0);
                            mem_rd   <= 1'b1;
                            state    <= RD_MEM;
                        end else begin
                            state <= WR_ADDR;
                        end
                    end
                end
                RD_MEM: begin
                    if (mem_ready) begin
                        mem_rd <= 1'b0;
                        if (load_active) begin
                            sd_ack <= 1'b0;
                            state  <= DONE;
                        end else begin
                            sd_buff_addr <= idx;
                            sd_buff_dout <= mem_din;
                            sd_buff_wr   <= 1'b1;
                            state        <= RD_PUT;
                        end
                    end
                end
                RD_PUT: begin
                    if (load_active) begin
                        sd_ack <= 1'b0;
                        state  <= DONE;
                    end else begin
                        state <= NEXT;
                    end
                end
                WR_ADDR: begin
                    if (load_active) begin
                        sd_ack <= 1'b0;
                        state  <= DONE;
                    end else begin
                        state <= null_xfer ? NEXT : WR_MEM;
                    end
                end
                // First cycle picks up sd_buff_din, then holds the write until mem_ready
                WR_MEM: begin
                    if (!mem_we) begin
                        if (load_active) begin
                            sd_ack <= 1'b0;
                            state  <= DONE;
                        end else begin
                            mem_addr <= sector_addr(BASE_ADDR, lba_q, idx);
                            mem_dout <= sd_buff_din;
                            mem_we   <= 1'b1;
                        end
                    end else if (mem_ready) begin
                        mem_we <= 1'b0;
                        if (load_active) begin
                            sd_ack <= 1'b0;
                            state  <= DONE;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (load_active || (idx == LAST_IDX)) begin
                        sd_ack <= 1'b0;
                        state  <= DONE;
                    end else begin
                        idx          <= idx_nxt;
                        sd_buff_addr <= idx_nxt;
                        if (!rd_xfer) begin
                            state <= WR_ADDR;
                        end else if (null_xfer) begin
                            sd_buff_dout <= NULL_BYTE;
                            sd_buff_wr   <= 1'b1;
                            state        <= RD_PUT;
                        end else begin
                            mem_addr <= sector_addr(BASE_ADDR, lba_q, idx_nxt);
                            mem_rd   <= 1'b1;
                            state    <= RD_MEM;
                        end
                    end
                end
                DONE: begin
                    if (!sd_rd && !sd_wr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_ram_server.sv
// Directed self-checking bench for sd_ram_server with an SDRAM and sector-buffer model.
module tb_sd_ram_server;

    localparam logic [24:0] TB_BASE = 25'h0100000;
    localparam int LAT = 2;
    localparam int XFER_BOUND = 512 * ((LAT + 1) + 3) + 2;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        load_active;
    logic        load_wr;
    logic [24:0] load_addr;
    logic        img_mounted;
    logic [31:0] img_size;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic        mem_we;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_ready;

    int errors = 0;
    int checks = 0;

    sd_ram_server #(
        .BASE_ADDR(TB_BASE),
        .MAX_SIZE (32'd1048576)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .load_active (load_active),
        .load_wr     (load_wr),
        .load_addr   (load_addr),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_addr(sd_buff_addr),
        .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr  (sd_buff_wr),
        .sd_buff_din (sd_buff_din),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .mem_ready   (mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM model: fixed latency, pattern sdram[off] = off[7:0] restored on reset
    logic [7:0]  sdram [0:4095];
    logic [7:0]  txbuf [0:511];
    logic [7:0]  rx    [0:511];
    logic [24:0] mem_off;
    int mem_cnt = 0;
    int rd_done = 0;
    int we_done = 0;
    int oob_err = 0;

    assign mem_off = mem_addr - TB_BASE;

    always @(posedge clk_sys) begin
        if (reset) begin
            mem_ready <= 1'b0;
            mem_cnt   <= 0;
            for (int i = 0; i < 4096; i++) sdram[i] <= 8'(i);
        end else begin
            mem_ready <= 1'b0;
            if ((mem_rd || mem_we) && !mem_ready) begin
                if (mem_cnt == LAT - 1) begin
                    mem_ready <= 1'b1;
                    mem_cnt   <= 0;
                    if (mem_off < 25'd4096) begin
                        if (mem_rd) mem_din <= sdram[mem_off[11:0]];
                        if (mem_we) sdram[mem_off[11:0]] <= mem_dout;
                    end else begin
                        oob_err <= oob_err + 1;
                    end
                    if (mem_rd) rd_done <= rd_done + 1;
                    if (mem_we) we_done <= we_done + 1;
                end else begin
                    mem_cnt <= mem_cnt + 1;
                end
            end else begin
                mem_cnt <= 0;
            end
        end
    end

    // Controller sector buffer: registered read port
    always @(posedge clk_sys) sd_buff_din <= txbuf[sd_buff_addr];

    // Protocol monitor sampled on the falling edge
    int buff_wr_cnt = 0;
    int order_err = 0;
    int ack_err = 0;
    int rd_req = 0;
    int excl_err = 0;
    int stab_err = 0;
    int exp_idx = 0;
    logic        prev_rd = 1'b0;
    logic        prev_we = 1'b0;
    logic        prev_ack = 1'b0;
    logic [24:0] prev_addr = '0;
    logic [7:0]  prev_dout = '0;

    always @(negedge clk_sys) begin
        if (sd_ack && !prev_ack) exp_idx = 0;
        if (sd_buff_wr) begin
            if (int'(sd_buff_addr) != exp_idx) order_err++;
            if (!sd_ack) ack_err++;
            rx[sd_buff_addr] = sd_buff_dout;
            exp_idx++;
            buff_wr_cnt++;
        end
        if (mem_rd && mem_we) excl_err++;
        if (prev_rd && mem_rd && (mem_addr != prev_addr)) stab_err++;
        if (prev_we && mem_we && ((mem_addr != prev_addr) || (mem_dout != prev_dout))) stab_err++;
        if (mem_rd && !prev_rd) rd_req++;
        prev_rd   = mem_rd;
        prev_we   = mem_we;
        prev_ack  = sd_ack;
        prev_addr = mem_addr;
        prev_dout = mem_dout;
    end

    task automatic do_load(input logic [24:0] first, input int n, output int pulses);
        @(negedge clk_sys);
        load_active = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_sys);
            load_wr   = 1'b1;
            load_addr = first + 25'(n - 1 - i);
        end
        @(negedge clk_sys);
        load_wr = 1'b0;
        @(negedge clk_sys);
        load_active = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk_sys);
            if (img_mounted) pulses++;
        end
    endtask

    task automatic run_xfer(input logic rd, input logic wr, input logic [31:0] lba, input int hold,
                            output int cycles, output int reack, output bit ok);
        int n;
        @(negedge clk_sys);
        sd_lba = lba;
        sd_rd  = rd;
        sd_wr  = wr;
        ok = 1'b1;
        cycles = 0;
        reack = 0;
        n = 0;
        while (!sd_ack && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        if (!sd_ack) begin
            ok = 1'b0;
        end else begin
            while (sd_ack && cycles < 20000) begin
                @(negedge clk_sys);
                cycles++;
            end
            if (sd_ack) ok = 1'b0;
        end
        repeat (hold) begin
            @(negedge clk_sys);
            if (sd_ack) reack++;
        end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        @(negedge clk_sys);
        checks++; if (sd_ack !== 1'b0) begin errors++; $display("FAIL reset_sd_ack got=%b exp=0", sd_ack); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        checks++; if (sd_buff_wr !== 1'b0) begin errors++; $display("FAIL reset_buff_wr got=%b exp=0", sd_buff_wr); end
        checks++; if (img_mounted !== 1'b0) begin errors++; $display("FAIL reset_mounted got=%b exp=0", img_mounted); end
        checks++; if (img_size !== 32'd0) begin errors++; $display("FAIL reset_img_size got=%0d exp=0", img_size); end
    endtask

    task automatic test_unmounted_read();
        int cyc, reack, b0, r0, bad;
        bit ok;
        b0 = buff_wr_cnt; r0 = rd_req;
        run_xfer(1'b1, 1'b0, 32'd0, 0, cyc, reack, ok);
        bad = 0;
        for (int i = 0; i < 512; i++) if (rx[i] !== 8'hFF) bad++;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL unmounted_done got=%b exp=1", ok); end
        checks++; if (buff_wr_cnt - b0 !== 512) begin errors++; $display("FAIL unmounted_pulses got=%0d exp=512", buff_wr_cnt - b0); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL unmounted_data bad_bytes=%0d exp=0", bad); end
        checks++; if (rd_req - r0 !== 0) begin errors++; $display("FAIL unmounted_mem_rd got=%0d exp=0", rd_req - r0); end
    endtask

    task automatic test_load();
        int pulses;
        do_load(TB_BASE + 25'h0200000, 1, pulses);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL clip_pulses got=%0d exp=1", pulses); end
        checks++; if (img_size !== 32'd1048576) begin errors++; $display("FAIL clip_size got=%0d exp=1048576", img_size); end
        do_load(TB_BASE, 2048, pulses);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL load_pulses got=%0d exp=1", pulses); end
        checks++; if (img_size !== 32'd2048) begin errors++; $display("FAIL load_size got=%0d exp=2048", img_size); end
    endtask

    task automatic test_read();
        int cyc, reack, b0, d0, w0, bad;
        bit ok;
        b0 = buff_wr_cnt; d0 = rd_done; w0 = we_done;
        run_xfer(1'b1, 1'b0, 32'd3, 0, cyc, reack, ok);
        bad = 0;
        for (int i = 0; i < 512; i++) if (rx[i] !== 8'(3 * 512 + i)) bad++;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL read_done got=%b exp=1", ok); end
        checks++; if (buff_wr_cnt - b0 !== 512) begin errors++; $display("FAIL read_pulses got=%0d exp=512", buff_wr_cnt - b0); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL read_data bad_bytes=%0d exp=0", bad); end
        checks++; if (rd_done - d0 !== 512) begin errors++; $display("FAIL read_mem_acc got=%0d exp=512", rd_done - d0); end
        checks++; if (we_done - w0 !== 0) begin errors++; $display("FAIL read_mem_we got=%0d exp=0", we_done - w0); end
        checks++; if (cyc > XFER_BOUND) begin errors++; $display("FAIL read_latency got=%0d exp<=%0d", cyc, XFER_BOUND); end
    endtask

    task automatic test_write();
        int cyc, reack, b0, w0, bad;
        bit ok;
        for (int i = 0; i < 512; i++) txbuf[i] = ~8'(i);
        b0 = buff_wr_cnt; w0 = we_done;
        run_xfer(1'b0, 1'b1, 32'd1, 0, cyc, reack, ok);
        bad = 0;
        for (int i = 0; i < 512; i++) if (sdram[512 + i] !== ~8'(i)) bad++;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL write_done got=%b exp=1", ok); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL write_data bad_bytes=%0d exp=0", bad); end
        checks++; if (we_done - w0 !== 512) begin errors++; $display("FAIL write_mem_we got=%0d exp=512", we_done - w0); end
        checks++; if (buff_wr_cnt - b0 !== 0) begin errors++; $display("FAIL write_buff_wr got=%0d exp=0", buff_wr_cnt - b0); end
        checks++; if (sdram[1024] !== 8'h00) begin errors++; $display("FAIL write_neighbour got=%h exp=00", sdram[1024]); end
    endtask

    task automatic test_null_read();
        int cyc, reack, b0, r0, bad;
        bit ok;
        b0 = buff_wr_cnt; r0 = rd_req;
        run_xfer(1'b1, 1'b0, 32'd4, 0, cyc, reack, ok);
        bad = 0;
        for (int i = 0; i < 512; i++) if (rx[i] !== 8'hFF) bad++;
        checks++; if (buff_wr_cnt - b0 !== 512) begin errors++; $display("FAIL null_pulses got=%0d exp=512", buff_wr_cnt - b0); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL null_data bad_bytes=%0d exp=0", bad); end
        checks++; if (rd_req - r0 !== 0) begin errors++; $display("FAIL null_mem_rd got=%0d exp=0", rd_req - r0); end
    endtask

    task automatic test_both();
        int cyc, reack, b0, w0, bad;
        bit ok;
        b0 = buff_wr_cnt; w0 = we_done;
        run_xfer(1'b1, 1'b1, 32'd2, 20, cyc, reack, ok);
        bad = 0;
        for (int i = 0; i < 512; i++) if (rx[i] !== 8'(2 * 512 + i)) bad++;
        checks++; if (buff_wr_cnt - b0 !== 512) begin errors++; $display("FAIL both_pulses got=%0d exp=512", buff_wr_cnt - b0); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL both_data bad_bytes=%0d exp=0", bad); end
        checks++; if (we_done - w0 !== 0) begin errors++; $display("FAIL both_mem_we got=%0d exp=0", we_done - w0); end
        checks++; if (reack !== 0) begin errors++; $display("FAIL both_reack got=%0d exp=0", reack); end
    endtask

    task automatic test_reset_mid();
        int cyc, reack, b0, n, pulses, bad;
        bit ok;
        b0 = buff_wr_cnt;
        @(negedge clk_sys);
        sd_lba = 32'd3;
        sd_rd  = 1'b1;
        n = 0;
        while ((buff_wr_cnt - b0 < 100) && n < 5000) begin
            @(negedge clk_sys);
            n++;
        end
        checks++; if (buff_wr_cnt - b0 < 100) begin errors++; $display("FAIL mid_progress got=%0d exp>=100", buff_wr_cnt - b0); end
        reset = 1'b1;
        sd_rd = 1'b0;
        @(negedge clk_sys);
        checks++; if (sd_ack !== 1'b0) begin errors++; $display("FAIL mid_sd_ack got=%b exp=0", sd_ack); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL mid_mem_rd got=%b exp=0", mem_rd); end
        reset = 1'b0;
        do_load(TB_BASE, 2048, pulses);
        b0 = buff_wr_cnt;
        run_xfer(1'b1, 1'b0, 32'd3, 0, cyc, reack, ok);
        bad = 0;
        for (int i = 0; i < 512; i++) if (rx[i] !== 8'(3 * 512 + i)) bad++;
        checks++; if (buff_wr_cnt - b0 !== 512) begin errors++; $display("FAIL mid_again_pulses got=%0d exp=512", buff_wr_cnt - b0); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_again_data bad_bytes=%0d exp=0", bad); end
    endtask

    task automatic test_protocol();
        checks++; if (order_err !== 0) begin errors++; $display("FAIL buff_order got=%0d exp=0", order_err); end
        checks++; if (ack_err !== 0) begin errors++; $display("FAIL ack_during_wr got=%0d exp=0", ack_err); end
        checks++; if (excl_err !== 0) begin errors++; $display("FAIL rd_we_overlap got=%0d exp=0", excl_err); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL req_stability got=%0d exp=0", stab_err); end
        checks++; if (oob_err !== 0) begin errors++; $display("FAIL mem_range got=%0d exp=0", oob_err); end
    endtask

    initial begin
        reset       = 1'b1;
        load_active = 1'b0;
        load_wr     = 1'b0;
        load_addr   = '0;
        sd_lba      = '0;
        sd_rd       = 1'b0;
        sd_wr       = 1'b0;
        for (int i = 0; i < 512; i++) txbuf[i] = 8'h00;
        test_reset();
        test_unmounted_read();
        test_load();
        test_read();
        test_write();
        test_null_read();
        test_both();
        test_reset_mid();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_ram_server.md
SD_RAM_SERVER -- requirements
Module: sd_ram_server

Interface
REQ-001 Parameter BASE_ADDR, default 25'h0100000, is the SDRAM byte address of disk image byte 0.
REQ-002 Parameter MAX_SIZE, default 32'd1048576, is the largest image in bytes that the block accepts.
REQ-003 clk_sys  in  1  system clock (96 MHz); all logic runs on its rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 load_active  in  1  high while the disk image is being written into SDRAM by ioctl.
REQ-006 load_wr  in  1  one-cycle strobe for each image byte written.
REQ-007 load_addr  in  25  SDRAM address of that image byte.
REQ-008 img_mounted  out  1  one-cycle pulse when a load completes.
REQ-009 img_size  out  32  image size in bytes, valid from the img_mounted pulse onward.
REQ-010 sd_lba  in  32  sector number requested by the disk controller.
REQ-011 sd_rd, sd_wr  in  1 each  sector read and sector write requests (level).
REQ-012 sd_ack  out  1  high for the whole duration of a sector transfer.
REQ-013 sd_buff_addr  out  9  byte index into the controller's sector buffer.
REQ-014 sd_buff_dout  out  8  byte sent to the controller.
REQ-015 sd_buff_wr  out  1  one-cycle write strobe into the controller's buffer.
REQ-016 sd_buff_din  in  8  byte from the controller; valid one cycle after sd_buff_addr is presented.
REQ-017 mem_addr  out  25  SDRAM byte address.
REQ-018 mem_rd, mem_we  out  1 each  SDRAM access requests, held high until mem_ready.
REQ-019 mem_dout  out  8  SDRAM write data.
REQ-020 mem_din  in  8  SDRAM read data, valid in the mem_ready cycle.
REQ-021 mem_ready  in  1  one-cycle completion pulse for the current SDRAM access.

Function
REQ-022 Load tracking: while load_active is high, each load_wr sets size to max(size, load_addr-BASE_ADDR+1); a rising edge of load_active clears size to 0.
REQ-023 On the falling edge of load_active: img_size is set to min(size, MAX_SIZE), and img_mounted pulses for exactly one cycle.
REQ-024 The FSM has seven states: IDLE, RD_MEM, RD_PUT, WR_ADDR, WR_MEM, NEXT, DONE.
REQ-025 In IDLE the FSM samples requests only when load_active is low; sd_rd has priority over sd_wr.
  - On a request it latches sd_lba, sets the byte index to 0, asserts sd_ack the next cycle, and goes to RD_MEM (read) or WR_ADDR (write).
REQ-026 A sector is in range when (lba+1)*512 <= img_size, computed in 42-bit arithmetic.
  - A sector that is out of range, or any sector before the first mount, is a null transfer.
REQ-027 Read path, per byte:
  - RD_MEM: mem_rd=1 with mem_addr=BASE_ADDR+lba*512+index (truncated to 25 bits) until mem_ready; capture mem_din.
  - RD_PUT: sd_buff_addr=index, sd_buff_dout=captured byte, sd_buff_wr=1 for one cycle.
  - A null read skips RD_MEM and supplies 8'hFF.
REQ-028 Write path, per byte:
  - WR_ADDR: sd_buff_addr=index; wait one cycle for sd_buff_din.
  - WR_MEM: mem_we=1 with mem_dout=sd_buff_din until mem_ready.
  - A null write skips WR_MEM; the data is discarded.
REQ-029 NEXT: if the index is 511, go to DONE; otherwise increment the index and return to RD_MEM or WR_ADDR.
REQ-030 DONE: deassert sd_ack and wait until sd_rd and sd_wr are both low, then go to IDLE, so no request is served twice.
REQ-031 Each sector produces exactly 512 sd_buff_wr pulses (read) or 512 mem_we accesses (write, unless null), in ascending index order.
REQ-032 mem_rd and mem_we are never high together; address and data are stable while a request is pending.
REQ-033 load_active rising mid-transfer: the current SDRAM access completes, the FSM goes directly to DONE, and the remaining bytes are not transferred.
REQ-034 Latency: sd_ack rises 1 cycle after the request is sampled; total transfer time is ≤ 512*(memory latency + 3) + 2 cycles.

Reset
REQ-035 Reset returns the FSM to IDLE and clears sd_ack, sd_buff_wr, mem_rd, mem_we, img_mounted, sd_buff_addr, sd_buff_dout and the tracked size.
  - img_size resets to 0, which marks "not mounted".
REQ-036 Reset mid-transfer abandons the transfer immediately; any pending mem_ready pulse is ignored.

Structure
REQ-037 The FSM state enum and SECTOR_BYTES=512 are defined in the shared package specialist_pkg.
REQ-038 The design is a single module with no sub-modules.

Verification
REQ-039 Load 2048 bytes at BASE_ADDR (load_active pulse) -> exactly one img_mounted pulse; img_size=2048.
REQ-040 sd_rd=1, lba=3, SDRAM filled with pattern addr[7:0] -> 512 sd_buff_wr pulses, byte i = (3*512+i)[7:0], sd_ack high throughout.
REQ-041 sd_wr=1, lba=1, buffer byte i = ~i -> SDRAM at BASE_ADDR+512+i holds ~i; no sd_buff_wr pulses.
REQ-042 sd_rd with lba=4 against img_size=2048 -> 512 bytes of 8'hFF; zero mem_rd requests.
REQ-043 sd_rd and sd_wr asserted together -> read served; sd_ack stays low until both requests drop.
REQ-044 Reset asserted at byte 100 of a read -> next cycle sd_ack=0, mem_rd=0; a following request transfers normally from byte 0.
